// File: rtl/digit_recognizer_pkg.sv
// Shared constants and types for the digit recognizer SPI front end.
// Command codes, response codes and the command FSM state encoding.
package digit_recognizer_pkg;

  localparam int IMG_BYTES   = 72;
  localparam int SYNC_STAGES = 2;

  localparam logic [7:0] CMD_LOAD  = 8'h00;
  localparam logic [7:0] CMD_COST  = 8'h01;
  localparam logic [7:0] CMD_START = 8'hFF;
  localparam logic [7:0] ERR_CODE  = 8'hFF;
  localparam logic [7:0] MAX_DIGIT = 8'd9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOADED,
    BUSY,
    COST_ARG,
    COST_WAIT
  } state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI slave bit layer: input synchronisers, SCK/SS edge detect,
// LSB-first receive and transmit shift registers.
module spi_byte_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sck_i,
  input  logic       ss_i,
  input  logic       mosi_i,
  input  logic [7:0] resp_i,
  output logic       miso_o,
  output logic       byte_rdy_o,
  output logic [7:0] rx_byte_o,
  output logic       ss_rise_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   ss_prev_q;
  logic [7:0]             rx_q;
  logic [7:0]             rx_byte_q;
  logic [2:0]             rx_cnt_q;
  logic                   byte_rdy_q;
  logic [7:0]             tx_q;
  logic [2:0]             tx_cnt_q;

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, ss_fall, ss_rise;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;

  assign miso_o     = tx_q[0] & ~ss_s;
  assign byte_rdy_o = byte_rdy_q;
  assign rx_byte_o  = rx_byte_q;
  assign ss_rise_o  = ss_rise;

  // SS synchronisers reset to the deselected level
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_q       <= '0;
      rx_byte_q  <= '0;
      rx_cnt_q   <= '0;
      byte_rdy_q <= 1'b0;
    end else begin
      byte_rdy_q <= 1'b0;
      if (ss_rise) begin
        rx_q     <= '0;
        rx_cnt_q <= '0;
      end else if (!ss_s && sck_rise) begin
        rx_q     <= {mosi_s, rx_q[7:1]};
        rx_cnt_q <= rx_cnt_q + 3'd1;
        if (rx_cnt_q == 3'd7) begin
          byte_rdy_q <= 1'b1;
          rx_byte_q  <= {mosi_s, rx_q[7:1]};
        end
      end
    end
  end

  // resp is only sampled at frame start and after each full byte
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_q     <= '0;
      tx_cnt_q <= '0;
    end else if (ss_fall) begin
      tx_q     <= resp_i;
      tx_cnt_q <= '0;
    end else if (ss_s) begin
      tx_q     <= '0;
      tx_cnt_q <= '0;
    end else if (sck_fall) begin
      tx_cnt_q <= tx_cnt_q + 3'd1;
      if (tx_cnt_q == 3'd7) begin
        tx_q <= resp_i;
      end else begin
        tx_q <= {1'b0, tx_q[7:1]};
      end
    end
  end

endmodule

// File: rtl/spi_cmd_interface.sv
// SPI slave command front end: decodes the byte stream into pixel
// writes, start and cost requests, and holds the MISO response byte.
module spi_cmd_interface #(
  parameter int IMG_BYTES   = digit_recognizer_pkg::IMG_BYTES,
  parameter int SYNC_STAGES = digit_recognizer_pkg::SYNC_STAGES
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       SCK,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  output logic       pix_wr_en,
  output logic [6:0] pix_waddr,
  output logic [7:0] pix_wdata,
  output logic       calc_start,
  input  logic       calc_done,
  input  logic [7:0] calc_digit,
  output logic       cost_req,
  output logic [3:0] cost_sel,
  input  logic       cost_done,
  input  logic [7:0] cost_value
);

  import digit_recognizer_pkg::*;

  state_t     state_q;
  logic [7:0] resp_q;
  logic       digit_valid_q;
  logic [6:0] addr_q;
  logic       pix_wr_en_q;
  logic [6:0] pix_waddr_q;
  logic [7:0] pix_wdata_q;
  logic       calc_start_q;
  logic       cost_req_q;
  logic [3:0] cost_sel_q;

  logic       byte_rdy;
  logic [7:0] rx_byte;
  logic       ss_rise;

  spi_byte_shifter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shifter (
    .clk       (clk),
    .n_rst     (n_rst),
    .sck_i     (SCK),
    .ss_i      (SS),
    .mosi_i    (MOSI),
    .resp_i    (resp_q),
    .miso_o    (MISO),
    .byte_rdy_o(byte_rdy),
    .rx_byte_o (rx_byte),
    .ss_rise_o (ss_rise)
  );

  assign pix_wr_en  = pix_wr_en_q;
  assign pix_waddr  = pix_waddr_q;
  assign pix_wdata  = pix_wdata_q;
  assign calc_start = calc_start_q;
  assign cost_req   = cost_req_q;
  assign cost_sel   = cost_sel_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      resp_q        <= 8'h00;
      digit_valid_q <= 1'b0;
      addr_q        <= '0;
      pix_wr_en_q   <= 1'b0;
      pix_waddr_q   <= '0;
      pix_wdata_q   <= '0;
      calc_start_q  <= 1'b0;
      cost_req_q    <= 1'b0;
      cost_sel_q    <= '0;
    end else begin
      pix_wr_en_q  <= 1'b0;
      calc_start_q <= 1'b0;
      cost_req_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (byte_rdy) begin
            unique case (1'b1)
              (rx_byte == CMD_LOAD): begin
                state_q       <= LOAD;
                addr_q        <= '0;
                resp_q        <= ERR_CODE;
                digit_valid_q <= 1'b0;
              end
              (rx_byte == CMD_COST): begin
                if (digit_valid_q) state_q <= COST_ARG;
                else resp_q <= ERR_CODE;
              end
              default: ;
            endcase
          end
        end
        LOAD: begin
          if (ss_rise) begin
            state_q <= IDLE;
            resp_q  <= ERR_CODE;
          end else if (byte_rdy) begin
            pix_wr_en_q <= 1'b1;
            pix_waddr_q <= addr_q;
            pix_wdata_q <= rx_byte;
            addr_q      <= addr_q + 7'd1;
            if (addr_q == 7'(IMG_BYTES - 1)) state_q <= LOADED;
          end
        end
        LOADED: begin
          if (byte_rdy) begin
            unique case (1'b1)
              (rx_byte == CMD_START): begin
                calc_start_q <= 1'b1;
                state_q      <= BUSY;
                resp_q       <= ERR_CODE;
              end
              (rx_byte == CMD_LOAD): begin
                state_q <= LOAD;
                addr_q  <= '0;
                resp_q  <= ERR_CODE;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (calc_done) begin
            resp_q        <= calc_digit;
            digit_valid_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            resp_q <= ERR_CODE;
          end
        end
        COST_ARG: begin
          if (byte_rdy) begin
            resp_q <= ERR_CODE;
            if (rx_byte <= MAX_DIGIT) begin
              cost_sel_q <= rx_byte[3:0];
              cost_req_q <= 1'b1;
              state_q    <= COST_WAIT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        COST_WAIT: begin
          if (cost_done) begin
            resp_q  <= cost_value;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
